ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter for the UP2 PS2_CLK/PS2_DATA (and FLEX_MOUSE_*) open-drain pins. It sends one command byte, e.g. keyboard LED 0xED or mouse enable 0xF4, using the standard request-to-send sequence. It then checks the device ACK and reports DONE or ERROR. It is the transmit counterpart to the PS/2 scancode receiver. The top level builds the tristates: PIN = OE ? 1'b0 : 1'bz.

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_host_tx_if.sv | 22 ++
 rtl/ps2_line_filter.sv | 52 +++++
 rtl/ps2_host_tx.sv | 162 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM states, frame geometry and the parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    SEND,
    ACK,
    WAIT_IDLE
  } state_e;

  localparam int unsigned FRAME_LEN = 11;
  localparam int unsigned BIT_IDX_W = 4;

  // Odd parity: the returned bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command/status and pin-level bundle of the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic [7:0] TX_DATA;
  logic       TX_START;
  logic       PS2_CLK_IN;
  logic       PS2_DATA_IN;
  logic       PS2_CLK_OE;
  logic       PS2_DATA_OE;
  logic       BUSY;
  logic       DONE;
  logic       ERROR;

  modport master (
    output TX_DATA, TX_START, PS2_CLK_IN, PS2_DATA_IN,
    input  PS2_CLK_OE, PS2_DATA_OE, BUSY, DONE, ERROR
  );

  modport slave (
    input  TX_DATA, TX_START, PS2_CLK_IN, PS2_DATA_IN,
    output PS2_CLK_OE, PS2_DATA_OE, BUSY, DONE, ERROR
  );
endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus a run-length filter; pulses fall_o on an accepted 1->0 change.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic fall_o
);

  localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             fall_q, fall_d;

  // A new level is taken only after FILTER_LEN consecutive differing samples.
  always_comb begin
    sync_d  = {sync_q[0], raw_i};
    cnt_d   = '0;
    level_d = level_q;
    fall_d  = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        level_d = sync_q[1];
        fall_d  = level_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: request-to-send, 11-bit frame, ACK check.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES    = 2600,
  parameter int unsigned START_HOLD_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES    = 500000,
  parameter int unsigned FILTER_LEN        = 8
) (
  input logic         MCLK,
  input logic         RESET_N,
  ps2_host_tx_if.slave io
);

  localparam int unsigned PH_MAX = (INHIBIT_CYCLES > START_HOLD_CYCLES) ?
                                   INHIBIT_CYCLES : START_HOLD_CYCLES;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

  state_e               state_q, state_d;
  logic [PH_W-1:0]      ph_cnt_q, ph_cnt_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [7:0]           data_q, data_d;
  logic                 par_q, par_d;
  logic [1:0]           dsync_q, dsync_d;
  logic                 clk_oe_q, clk_oe_d;
  logic                 data_oe_q, data_oe_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;

  logic                 clk_level, clk_fall;
  logic                 data_sync;
  logic                 timeout;
  logic [FRAME_LEN-1:0] frame;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk    (MCLK),
    .rst_n  (RESET_N),
    .raw_i  (io.PS2_CLK_IN),
    .level_o(clk_level),
    .fall_o (clk_fall)
  );

  assign data_sync = dsync_q[1];
  assign frame     = {1'b1, par_q, data_q, 1'b0};
  assign timeout   = (state_q inside {SEND, ACK, WAIT_IDLE}) &&
                     (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      ph_cnt_q  <= '0;
      tmo_q     <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      par_q     <= 1'b0;
      dsync_q   <= 2'b11;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_cnt_q  <= ph_cnt_d;
      tmo_q     <= tmo_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      par_q     <= par_d;
      dsync_q   <= dsync_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  // Next state; bit_idx counts device falling edges seen in SEND.
  always_comb begin
    state_d   = state_q;
    ph_cnt_d  = ph_cnt_q;
    tmo_d     = tmo_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    par_d     = par_q;
    dsync_d   = {dsync_q[0], io.PS2_DATA_IN};
    unique case (state_q)
      IDLE: begin
        ph_cnt_d = '0;
        // The cycle showing DONE/ERROR still counts as busy for new requests.
        if (io.TX_START && !done_q && !error_q) begin
          data_d  = io.TX_DATA;
          par_d   = odd_parity(io.TX_DATA);
          state_d = INHIBIT;
        end
      end
      INHIBIT: begin
        if (ph_cnt_q == PH_W'(INHIBIT_CYCLES - 1)) begin
          ph_cnt_d = '0;
          state_d  = START;
        end else begin
          ph_cnt_d = ph_cnt_q + PH_W'(1);
        end
      end
      START: begin
        if (ph_cnt_q == PH_W'(START_HOLD_CYCLES - 1)) begin
          ph_cnt_d  = '0;
          bit_idx_d = '0;
          tmo_d     = '0;
          state_d   = SEND;
        end else begin
          ph_cnt_d = ph_cnt_q + PH_W'(1);
        end
      end
      SEND: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (clk_fall) begin
          bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
          if (bit_idx_q == BIT_IDX_W'(FRAME_LEN - 2)) state_d = ACK;
        end
      end
      ACK: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (clk_fall) state_d = data_sync ? IDLE : WAIT_IDLE;
      end
      WAIT_IDLE: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (clk_level && data_sync) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (timeout) state_d = IDLE;
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    clk_oe_d  = 1'b0;
    data_oe_d = 1'b0;
    busy_d    = (state_d != IDLE);
    error_d   = timeout || ((state_q == ACK) && clk_fall && data_sync);
    done_d    = !timeout && (state_q == WAIT_IDLE) && clk_level && data_sync;
    unique case (state_d)
      INHIBIT: clk_oe_d = 1'b1;
      START: begin
        clk_oe_d  = 1'b1;
        data_oe_d = 1'b1;
      end
      SEND:    data_oe_d = ~frame[bit_idx_d];
      default: ;
    endcase
  end

  assign io.PS2_CLK_OE  = clk_oe_q;
  assign io.PS2_DATA_OE = data_oe_q;
  assign io.BUSY        = busy_q;
  assign io.DONE        = done_q;
  assign io.ERROR       = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomized bench for ps2_host_tx with a behavioural PS/2 device and frame model.
module tb_ps2_host_tx;

  localparam int INH  = 200;
  localparam int HOLD = 16;
  localparam int TMO  = 4000;
  localparam int FL   = 8;
  localparam int HALF = 40;

  logic MCLK = 1'b0;
  logic RESET_N;
  logic dev_clk, dev_data;
  logic clk_line, data_line;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic prev_busy = 1'b0;
  logic prev_doe = 1'b0;

  ps2_host_tx_if bus ();

  assign clk_line        = dev_clk & ~bus.PS2_CLK_OE;
  assign data_line       = dev_data & ~bus.PS2_DATA_OE;
  assign bus.PS2_CLK_IN  = clk_line;
  assign bus.PS2_DATA_IN = data_line;

  ps2_host_tx #(
    .INHIBIT_CYCLES   (INH),
    .START_HOLD_CYCLES(HOLD),
    .TIMEOUT_CYCLES   (TMO),
    .FILTER_LEN       (FL)
  ) dut (
    .MCLK   (MCLK),
    .RESET_N(RESET_N),
    .io     (bus)
  );

  always #5 MCLK = ~MCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame as the device sees it: start 0, data LSB-first, odd parity, stop 1.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic p;
    p = 1'b1;
    for (int i = 0; i < 8; i++) p = p ^ b[i];
    return {1'b1, p, b, 1'b0};
  endfunction

  // Per-cycle protocol rules.
  always @(negedge MCLK) begin
    if (RESET_N) begin
      if (bus.DONE) done_cnt++;
      if (bus.ERROR) err_cnt++;
      chk("done_error_exclusive", {31'd0, bus.DONE & bus.ERROR}, 0);
      if (bus.DONE || bus.ERROR) chk("busy_low_at_pulse", {31'd0, bus.BUSY}, 0);
      if (prev_busy && !bus.BUSY) chk("busy_falls_with_pulse", {31'd0, bus.DONE | bus.ERROR}, 1);
      if (!bus.BUSY) chk("idle_lines_released", {30'd0, bus.PS2_CLK_OE, bus.PS2_DATA_OE}, 0);
      if (bus.PS2_DATA_OE != prev_doe && !bus.ERROR)
        chk("data_changes_while_clock_low", {31'd0, clk_line}, 0);
      prev_busy = bus.BUSY;
      prev_doe  = bus.PS2_DATA_OE;
    end else begin
      prev_busy = 1'b0;
      prev_doe  = 1'b0;
    end
  end

  task automatic request(input logic [7:0] b, input string tag);
    @(negedge MCLK);
    bus.TX_DATA  = b;
    bus.TX_START = 1'b1;
    @(negedge MCLK);
    bus.TX_START = 1'b0;
    bus.TX_DATA  = 8'($urandom);
    chk({tag, "_busy_after_start"}, {31'd0, bus.BUSY}, 1);
  endtask

  task automatic wait_release(input string tag);
    int n;
    n = 0;
    while (bus.PS2_CLK_OE && !bus.PS2_DATA_OE && n < INH + 100) begin
      @(negedge MCLK);
      n++;
    end
    chk({tag, "_inhibit_long_enough"}, {31'd0, n >= INH}, 1);
    n = 0;
    while (bus.PS2_CLK_OE && bus.PS2_DATA_OE && n < HOLD + 100) begin
      @(negedge MCLK);
      n++;
    end
    chk({tag, "_start_hold_long_enough"}, {31'd0, n >= HOLD}, 1);
    chk({tag, "_released_with_start_bit"}, {30'd0, bus.PS2_CLK_OE, bus.PS2_DATA_OE}, 1);
  endtask

  task automatic serve(input logic [7:0] b, input bit ack, input bit glitch, input bit mid_start,
                       input bit rst_mid, input bit coinc, input string tag,
                       output logic [10:0] got);
    int n, d0, e0;
    got = '0;
    d0 = done_cnt;
    e0 = err_cnt;
    request(b, tag);
    wait_release(tag);
    got[0] = data_line;
    for (int k = 1; k <= 11; k++) begin
      if (glitch && k == 3) begin
        repeat (10) @(negedge MCLK);
        dev_clk = 1'b0;
        repeat (3) @(negedge MCLK);
        dev_clk = 1'b1;
        repeat (HALF - 13) @(negedge MCLK);
      end else begin
        repeat (HALF) @(negedge MCLK);
      end
      dev_clk = 1'b0;
      if (k == 11 && ack) dev_data = 1'b0;
      if (mid_start && k == 3) begin
        @(negedge MCLK);
        bus.TX_DATA  = 8'h00;
        bus.TX_START = 1'b1;
        @(negedge MCLK);
        bus.TX_START = 1'b0;
      end
      if (rst_mid && k == 5) begin
        repeat (20) @(negedge MCLK);
        RESET_N = 1'b0;
        #1;
        chk({tag, "_reset_releases"},
            {27'd0, bus.PS2_CLK_OE, bus.PS2_DATA_OE, bus.BUSY, bus.DONE, bus.ERROR}, 0);
        repeat (3) @(negedge MCLK);
        RESET_N  = 1'b1;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        repeat (10) @(negedge MCLK);
        chk({tag, "_no_pulse_after_reset"}, done_cnt - d0 + err_cnt - e0, 0);
        chk({tag, "_idle_after_reset"}, {29'd0, bus.PS2_CLK_OE, bus.PS2_DATA_OE, bus.BUSY}, 0);
        return;
      end
      repeat (HALF) @(negedge MCLK);
      dev_clk = 1'b1;
      if (k <= 10) got[k] = data_line;
    end
    repeat (5) @(negedge MCLK);
    dev_data = 1'b1;
    n = 0;
    while (!bus.DONE && !bus.ERROR && done_cnt == d0 && err_cnt == e0 && n < 300) begin
      @(negedge MCLK);
      n++;
    end
    if (coinc && bus.DONE) begin
      bus.TX_DATA  = 8'($urandom);
      bus.TX_START = 1'b1;
      @(negedge MCLK);
      bus.TX_START = 1'b0;
      @(negedge MCLK);
      chk({tag, "_start_on_final_cycle_ignored"}, {31'd0, bus.BUSY}, 0);
    end
    repeat (10) @(negedge MCLK);
    chk({tag, "_done_pulses"}, done_cnt - d0, ack ? 1 : 0);
    chk({tag, "_error_pulses"}, err_cnt - e0, ack ? 0 : 1);
    chk({tag, "_idle_after_frame"}, {29'd0, bus.PS2_CLK_OE, bus.PS2_DATA_OE, bus.BUSY}, 0);
    chk({tag, "_frame_bits"}, {21'd0, got}, {21'd0, frame_of(b)});
  endtask

  task automatic timeout_case();
    int n, d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    request(8'($urandom), "tmo");
    n = 0;
    while (bus.PS2_CLK_OE && n < INH + HOLD + 100) begin
      @(negedge MCLK);
      n++;
    end
    n = 0;
    while (!bus.ERROR && n < TMO + 50) begin
      @(negedge MCLK);
      n++;
    end
    chk("tmo_error_latency", n, TMO);
    chk("tmo_idle_with_error", {29'd0, bus.PS2_CLK_OE, bus.PS2_DATA_OE, bus.BUSY}, 0);
    repeat (10) @(negedge MCLK);
    chk("tmo_error_pulses", err_cnt - e0, 1);
    chk("tmo_done_pulses", done_cnt - d0, 0);
  endtask

  initial begin
    logic [10:0] got;
    logic [7:0]  b;
    RESET_N      = 1'b0;
    bus.TX_START = 1'b0;
    bus.TX_DATA  = 8'h00;
    dev_clk      = 1'b1;
    dev_data     = 1'b1;
    repeat (3) @(negedge MCLK);
    chk("reset_outputs",
        {27'd0, bus.PS2_CLK_OE, bus.PS2_DATA_OE, bus.BUSY, bus.DONE, bus.ERROR}, 0);
    RESET_N = 1'b1;
    repeat (5) @(negedge MCLK);
    chk("post_reset_outputs",
        {27'd0, bus.PS2_CLK_OE, bus.PS2_DATA_OE, bus.BUSY, bus.DONE, bus.ERROR}, 0);

    serve(8'hF4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "f4", got);
    chk("f4_literal_frame", {21'd0, got}, 32'h5E8);
    serve(8'hED, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "ed", got);
    chk("ed_literal_frame", {21'd0, got}, 32'h7DA);
    serve(8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "nack", got);
    timeout_case();
    serve(8'($urandom), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "glitch_midstart", got);
    serve(8'($urandom), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "reset_mid", got);
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      serve(b, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "rand", got);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
